multi_core: RTL and testbench

- Array of NCORES identical fixed-point Taylor-polynomial evaluators sharing one signed input-sample bus.
- A round-robin scheduler hands each new sample to the next idle core.
- Each core evaluates a cubic Horner polynomial with a serial multiplier and pulses a per-core output enable when its result is ready.
- Block sits between the sample source (advances one sample per request cycle) and the result sink (writes results in core-index order).

---
 rtl/multi_core_if.sv | 38 +++
 rtl/multi_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_multi_core.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_core_if.sv
// -----------------------------------------------------------------------------
// multi_core_if
// Bundles the shared sample bus and the per-core result/handshake vectors of
// the multi_core evaluator array.
//
//   in      : shared signed sample, Q1.18 (driven by the sample source)
//   io_out  : core k result at [YW*k +: YW], signed Q10.18
//   req_in  : core k sample request at [4*k +: 4]; 4'd1 = request
//   out_en  : core k result strobe  at [4*k +: 4]; 4'd1 = valid
//
// Modports:
//   master : source/sink side (drives the sample, observes results)
//   slave  : the multi_core array
// -----------------------------------------------------------------------------
interface multi_core_if #(
    parameter int NCORES = 72,
    parameter int XW     = 19,
    parameter int YW     = 28
) ();
    logic signed [XW-1:0]     in;
    logic [NCORES*YW-1:0]     io_out;
    logic [NCORES*4-1:0]      req_in;
    logic [NCORES*4-1:0]      out_en;

    modport master (
        output in,
        input  io_out,
        input  req_in,
        input  out_en
    );

    modport slave (
        input  in,
        output io_out,
        output req_in,
        output out_en
    );
endinterface

// File: rtl/multi_core.sv
// -----------------------------------------------------------------------------
// multi_core
// Array of NCORES fixed-point cubic Taylor-polynomial evaluators that share one
// signed sample bus. A round-robin scheduler grants the next idle core each
// cycle; the granted core requests a sample, latches it, evaluates
//     acc = c3;  acc = sat((acc*x) >>> FRAC) + c_i   for i = 2..0
// with a serial shift-add multiplier, then strobes its result.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears all control state and io_out)
//   bus  : multi_core_if.slave (in, io_out, req_in, out_en)
//
// Per-core timeline (grant registered into REQ at cycle t):
//   REQ t, LOAD t+1 (latches in), CALC t+2..t+61, DONE t+62, IDLE t+63.
//
// Build option:
//   SATURATE_EN defined   -> every YW-bit reduction clamps to [-2^27, 2^27-1]
//   SATURATE_EN undefined -> reductions wrap (two's complement truncation)
// -----------------------------------------------------------------------------
module multi_core #(
    parameter int NCORES = 72,
    parameter int XW     = 19,
    parameter int YW     = 28,
    parameter int FRAC   = 18,
    parameter int ORDER  = 3,
    parameter logic signed [YW-1:0] COEF0 = YW'(262144),
    parameter logic signed [YW-1:0] COEF1 = YW'(262144),
    parameter logic signed [YW-1:0] COEF2 = YW'(131072),
    parameter logic signed [YW-1:0] COEF3 = YW'(43691)
) (
    input  logic        clk,
    input  logic        rst,
    multi_core_if.slave bus
);

    localparam int PW   = XW + YW;               // full-precision product width
    localparam int CNTW = $clog2(XW + 1);        // counts 0..XW within one step
    localparam int PTRW = $clog2(NCORES);

    // Cycles 0..XW-1 of a step accumulate partial products; cycle XW does the
    // shift/reduce/add. The multiplier MSB carries negative weight.
    localparam logic [CNTW-1:0] SIGNCNT = CNTW'(XW - 1);
    localparam logic [CNTW-1:0] ADDCNT  = CNTW'(XW);

    localparam logic [PTRW:0]   NC_W    = (PTRW+1)'(NCORES);
    localparam logic [PTRW-1:0] LASTIDX = PTRW'(NCORES - 1);

`ifdef SATURATE_EN
    localparam logic signed [PW-1:0] SAT_MAX = PW'({(YW-1){1'b1}});
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_CALC,
        S_DONE
    } state_t;

    // Reduce a wide signed value to YW bits (clamp or wrap depending on build).
    function automatic logic signed [YW-1:0] reduce(input logic signed [PW-1:0] v);
`ifdef SATURATE_EN
        if (v > SAT_MAX) begin
            return SAT_MAX[YW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[YW-1:0];
        end else begin
            return v[YW-1:0];
        end
`else
        return v[YW-1:0];
`endif
    endfunction

    // Coefficient added at the end of Horner step s.
    function automatic logic signed [YW-1:0] coef_sel(input logic [1:0] s);
        if (s == 2'd0) begin
            return COEF0;
        end else if (s == 2'd1) begin
            return COEF1;
        end else if (s == 2'd2) begin
            return COEF2;
        end else begin
            return COEF3;
        end
    endfunction

    logic [NCORES-1:0]    idle_v;
    logic [NCORES-1:0]    req_v;
    logic [NCORES-1:0]    done_v;
    logic [NCORES-1:0]    grant;
    logic [NCORES*YW-1:0] io_out_v;

    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [PTRW:0]   idx;
    logic            found;

    // -------------------------------------------------------------------------
    // Round-robin scheduler: first idle core at or above the pointer, wrapping.
    // -------------------------------------------------------------------------
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NCORES; off++) begin
            idx = {1'b0, ptr_q} + (PTRW+1)'(off);
            if (idx >= NC_W) begin
                idx = idx - NC_W;
            end
            if (!found && idle_v[idx[PTRW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[PTRW-1:0]]  = 1'b1;
                ptr_d                 = (idx[PTRW-1:0] == LASTIDX) ? '0
                                                                   : idx[PTRW-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Evaluator cores
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NCORES; k++) begin : g_core
        state_t                 st_q, st_d;
        logic [CNTW-1:0]        cnt_q, cnt_d;
        logic [1:0]             step_q, step_d;
        logic signed [YW-1:0]   res_q, res_d;
        logic signed [XW-1:0]   x_q, x_d;
        logic signed [YW-1:0]   acc_q, acc_d;
        logic signed [PW-1:0]   prod_q, prod_d;
        logic signed [PW-1:0]   partial;
        logic signed [PW-1:0]   shifted;
        logic signed [YW-1:0]   mul_red;
        logic signed [YW-1:0]   c_sel;
        logic signed [YW:0]     sum;
        logic signed [YW-1:0]   acc_new;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q   <= S_IDLE;
                cnt_q  <= '0;
                step_q <= '0;
                res_q  <= '0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                step_q <= step_d;
                res_q  <= res_d;
            end
        end

        // Datapath registers carry no reset; they are reloaded in LOAD.
        always_ff @(posedge clk) begin
            x_q    <= x_d;
            acc_q  <= acc_d;
            prod_q <= prod_d;
        end

        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_q;
            step_d  = step_q;
            res_d   = res_q;
            x_d     = x_q;
            acc_d   = acc_q;
            prod_d  = prod_q;
            partial = '0;
            shifted = '0;
            mul_red = '0;
            c_sel   = '0;
            sum     = '0;
            acc_new = '0;

            case (st_q)
                S_IDLE: begin
                    if (grant[k]) begin
                        st_d = S_REQ;
                    end
                end
                S_REQ: begin
                    st_d = S_LOAD;
                end
                S_LOAD: begin
                    x_d    = bus.in;
                    acc_d  = COEF3;
                    prod_d = '0;
                    cnt_d  = '0;
                    step_d = 2'(ORDER - 1);
                    st_d   = S_CALC;
                end
                S_CALC: begin
                    if (cnt_q != ADDCNT) begin
                        // One multiplier bit per cycle, multiplicand sign-extended.
                        partial = x_q[cnt_q] ? (PW'(acc_q) <<< cnt_q) : '0;
                        if (cnt_q == SIGNCNT) begin
                            partial = -partial;
                        end
                        prod_d = prod_q + partial;
                        cnt_d  = cnt_q + 1'b1;
                    end else begin
                        // Arithmetic shift floors toward minus infinity.
                        shifted = prod_q >>> FRAC;
                        mul_red = reduce(shifted);
                        c_sel   = coef_sel(step_q);
                        sum     = {mul_red[YW-1], mul_red} + {c_sel[YW-1], c_sel};
                        acc_new = reduce(PW'(sum));
                        acc_d   = acc_new;
                        prod_d  = '0;
                        cnt_d   = '0;
                        if (step_q == 2'd0) begin
                            res_d = acc_new;
                            st_d  = S_DONE;
                        end else begin
                            step_d = step_q - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    st_d = S_IDLE;
                end
                default: begin
                    st_d = S_IDLE;
                end
            endcase
        end

        assign idle_v[k]               = (st_q == S_IDLE);
        assign req_v[k]                = (st_q == S_REQ);
        assign done_v[k]               = (st_q == S_DONE);
        assign io_out_v[YW*k +: YW]    = res_q;
    end

    // -------------------------------------------------------------------------
    // Output packing
    // -------------------------------------------------------------------------
    always_comb begin
        bus.req_in = '0;
        bus.out_en = '0;
        for (int k = 0; k < NCORES; k++) begin
            bus.req_in[4*k +: 4] = req_v[k]  ? 4'd1 : 4'd0;
            bus.out_en[4*k +: 4] = done_v[k] ? 4'd1 : 4'd0;
        end
    end

    assign bus.io_out = io_out_v;

endmodule

// File: tb/tb_multi_core.sv
// -----------------------------------------------------------------------------
// tb_multi_core
// Directed testbench for multi_core: reset state, constant and signed samples,
// a 100-sample stream across the core wrap, reset during computation, and the
// large-coefficient overflow case (expectation depends on SATURATE_EN).
// -----------------------------------------------------------------------------
module tb_multi_core;
    localparam int NCORES = 72;
    localparam int XW     = 19;
    localparam int YW     = 28;
    localparam int LAT    = 62;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multi_core_if #(.NCORES(NCORES), .XW(XW), .YW(YW)) bus ();
    multi_core_if #(.NCORES(NCORES), .XW(XW), .YW(YW)) bus_big ();

    multi_core #(.NCORES(NCORES), .XW(XW), .YW(YW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_core #(.NCORES(NCORES), .XW(XW), .YW(YW), .COEF3(28'sd134217727)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (bus_big)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference reduction and Horner evaluation with default coefficients.
    function automatic longint red(input longint v);
`ifdef SATURATE_EN
        if (v > 134217727) return 134217727;
        if (v < -134217728) return -134217728;
        return v;
`else
        longint w;
        w = v & 64'h0000_0000_0FFF_FFFF;
        if (w > 134217727) w = w - 268435456;
        return w;
`endif
    endfunction

    function automatic longint horner(input longint x);
        longint c [4];
        longint acc;
        c[0] = 262144; c[1] = 262144; c[2] = 131072; c[3] = 43691;
        acc = c[3];
        for (int i = 2; i >= 0; i--) begin
            acc = red(red((acc * x) >>> 18) + c[i]);
        end
        return acc;
    endfunction

    int     stim [$];
    longint expv [$];

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs ncyc cycles after reset release, acting as source and sink.
    task automatic run_cycles(input int ncyc);
        int     nreq;
        int     got;
        int     nz;
        int     kk;
        int     fv;
        bit     pend;
        logic signed [XW-1:0] pend_x;
        int     e_core [$];
        longint e_val  [$];
        int     e_cyc  [$];
        nreq   = 0;
        got    = 0;
        pend   = 1'b0;
        pend_x = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (pend) bus.in = pend_x;
            pend = 1'b0;

            nz = 0; kk = -1; fv = 0;
            for (int k = 0; k < NCORES; k++) begin
                if (bus.req_in[4*k +: 4] != 4'd0) begin
                    nz++; kk = k; fv = int'(bus.req_in[4*k +: 4]);
                end
            end
            check("req_count", nz, 1);
            if (nz == 1) begin
                if (nreq < stim.size()) begin
                    check("req_core", kk, nreq % NCORES);
                    check("req_field", fv, 1);
                    e_core.push_back(kk);
                    e_val.push_back(expv[nreq]);
                    e_cyc.push_back(c + LAT);
                    pend_x = XW'(stim[nreq]);
                end else begin
                    pend_x = '0;
                end
                pend = 1'b1;
                nreq++;
            end

            nz = 0; kk = -1;
            for (int k = 0; k < NCORES; k++) begin
                if (bus.out_en[4*k +: 4] != 4'd0) begin
                    nz++; kk = k;
                end
            end
            check("oen_count", nz, (c >= LAT + 1) ? 1 : 0);
            if (nz == 1 && e_core.size() > 0) begin
                check("oen_core", kk, e_core[0]);
                check("oen_cycle", c, e_cyc[0]);
                check("oen_field", int'(bus.out_en[4*kk +: 4]), 1);
                check("result", $signed(bus.io_out[YW*kk +: YW]), e_val[0]);
                void'(e_core.pop_front());
                void'(e_val.pop_front());
                void'(e_cyc.pop_front());
                got++;
            end
            if (c == LAT) check("io_out_quiet", |bus.io_out, 0);
        end
        check("results_seen", got, stim.size());
    endtask

    int                   big_cyc;
    logic signed [YW-1:0] big_val;

    initial begin
        bus.in     = '0;
        bus_big.in = XW'(-262144);

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_req", |bus.req_in, 0);
        check("rst_oen", |bus.out_en, 0);
        check("rst_io",  |bus.io_out, 0);

        // Constant zero input
        @(negedge clk); rst = 1'b0;
        stim.delete(); expv.delete();
        for (int i = 0; i < 5; i++) begin
            stim.push_back(0); expv.push_back(262144);
        end
        run_cycles(LAT + 5);

        // +0.5 and -0.5 (floor shift on the negative path)
        reset_dut();
        stim.delete(); expv.delete();
        stim.push_back(131072);  expv.push_back(431445);
        stim.push_back(-131072); expv.push_back(158378);
        run_cycles(LAT + 2);

        // Stream 0..99 across the core 71 -> core 0 wrap
        reset_dut();
        stim.delete(); expv.delete();
        for (int i = 0; i < 100; i++) begin
            stim.push_back(i); expv.push_back(horner(longint'(i)));
        end
        run_cycles(LAT + 100);

        // Reset while results are being strobed and many cores are in CALC
        reset_dut();
        stim.delete(); expv.delete();
        for (int i = 0; i < 8; i++) begin
            stim.push_back(0); expv.push_back(262144);
        end
        run_cycles(70);
        #2 rst = 1'b1;
        #1;
        check("midrst_oen", |bus.out_en, 0);
        check("midrst_req", |bus.req_in, 0);
        check("midrst_io",  |bus.io_out, 0);
        reset_dut();
        stim.delete(); expv.delete();
        stim.push_back(131072); expv.push_back(431445);
        run_cycles(LAT + 1);

        // Large coefficient: overflow in the second Horner step
        reset_dut();
        big_cyc = -1;
        big_val = '0;
        for (int c = 1; c <= 80 && big_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (bus_big.out_en[3:0] != 4'd0) begin
                big_cyc = c;
                big_val = $signed(bus_big.io_out[YW-1:0]);
            end
        end
        check("big_cycle", big_cyc, LAT + 1);
`ifdef SATURATE_EN
        check("big_result", big_val, -133955583);
`else
        check("big_result", big_val, -134086655);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
